br_fetch_seq: RTL and testbench
===============================

# br_fetch_seq

Microcoded sequencer that drives the DataPath control strobes through an instruction fetch (T0–T2) and a conditional branch (T3–T6). It replaces hand-scripted per-state strobes with one registered FSM, and adds:
- start/done handshake;
- opcode decode with illegal-opcode exit;
- a taken/not-taken status;
- optional memory wait states.

It sits between the top-level controller and DataPath, and its outputs connect one-to-one onto DataPath control inputs.

## Interface
- OPC_W, 5, width of the IR opcode field
- ALU_W, 5, width of the ALU operation code
- ALU_INC, 5'b11111, ALU code for PC increment in T0
- ALU_ADD, 5'b00011, ALU code for PC + C in T5
- OPC_BR, 5'b10010, opcode of the br family (brzr/brnz/brpl/brmi)
- WAIT_MAX, 15, maximum T1 wait cycles before timeout (used only with MEM_WAIT_EN)

Ports:
- clock  in  1  system clock, all state changes on rising edge
- clear_n  in  1  synchronous, active-low reset
- start  in  1  request one fetch/branch sequence; sampled only in IDLE
- ir_opcode  in  OPC_W  IR[31:27], sampled in DEC
- con_out  in  1  DataPath CON flip-flop output, sampled in T6
- mem_rdy  in  1  memory read complete (used only with MEM_WAIT_EN)
- pc_out, mar_in, z_in, zlo_out, pc_in, mem_read, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out  out  1 each  DataPath strobes
- alu_code  out  ALU_W  ALU operation select
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a sequence ends
- taken  out  1  branch result, updated with done
- illegal  out  1  one-cycle pulse with done when the opcode is not OPC_BR
- timeout  out  1  one-cycle pulse with done on memory timeout (only with MEM_WAIT_EN)

## Operation
- States: IDLE, T0, T1, T2, DEC, T3, T4, T5, T6, FIN.
- IDLE: no strobes asserted. start=1 goes to T0. start in any other state is ignored (no queuing).
- T0: pc_out, mar_in, z_in asserted; alu_code=ALU_INC.
- T1: zlo_out, pc_in, mem_read, mdr_in asserted.
- T2: mdr_out, ir_in asserted.
- DEC: no strobes asserted.
  - ir_opcode==OPC_BR goes to T3.
  - Any other opcode goes to FIN with illegal_q set.
- T3: gra, r_out, con_in asserted.
- T4: pc_out, y_in asserted.
- T5: c_out, z_in asserted; alu_code=ALU_ADD.
- T6: zlo_out and pc_in are asserted only while con_out=1; taken_q is set to con_out.
- FIN: done=1. illegal and timeout pulse here if their flags are set. Next state is IDLE.
- alu_code is 0 in every state other than T0 and T5.
- taken holds its value between sequences and is cleared to 0 on an illegal or timeout exit.
- Strobes are a Moore decode of the state register. The only exception is the T6 pair (zlo_out, pc_in), which is gated combinationally by con_out.

## Timing
- Every output is 0 while clear_n=0 and on the first cycle after reset. The state is IDLE.
- A reset in any state returns to IDLE at the next edge. Strobes drop in that same cycle, no done pulse is produced, and taken is cleared.
- Branch latency, with start sampled high at edge 0:
  - T0 during cycle 1, T1 cycle 2, T2 cycle 3, DEC cycle 4;
  - T3 through T6 during cycles 5–8;
  - FIN (done) in cycle 9;
  - IDLE in cycle 10.
- Illegal-opcode latency: FIN in cycle 5.
- The earliest back-to-back restart is start sampled in the first IDLE cycle after FIN.
- con_in in T3 precedes T6 by 3 cycles, so con_out is stable when it is sampled.
- WAIT_MAX must be at least 1. The wait counter is $clog2(WAIT_MAX+1) bits wide and saturates; it never wraps.

## Configuration
- MEM_WAIT_EN defined:
  - T1 holds, keeping its strobes asserted, until mem_rdy=1, then goes to T2.
  - After WAIT_MAX extra cycles without mem_rdy, the FSM goes to FIN with timeout pulsed and taken=0.
  - If mem_rdy arrives in the same cycle the limit is reached, mem_rdy wins.
- MEM_WAIT_EN undefined:
  - T1 lasts exactly one cycle; mem_rdy is ignored.
  - The timeout port is tied to 0, and the counter logic is absent.

## Structure
- Shared package br_seq_pkg holds:
  - the state enum;
  - ALU code constants (ALU_INC_C, ALU_ADD_C);
  - the OPC_BR_C opcode constant.
- Sub-module mem_wait_timer holds the saturating T1 wait counter with clear, enable and limit-reached outputs. It is instantiated only under MEM_WAIT_EN.

## Test plan
- Branch taken: start=1, ir_opcode=5'b10010, con_out=1 -> the exact T0–T6 strobe sequence; zlo_out and pc_in high in cycle 8; done and taken=1 in cycle 9.
- Branch not taken: same stimulus with con_out=0 -> no pc_in in cycle 8; done with taken=0.
- Illegal opcode: ir_opcode=5'b00011 -> no T3–T6 strobes; done and illegal pulse in cycle 5; taken=0.
- Reset mid-operation: clear_n=0 during T4 -> all outputs 0 in the next cycle; busy=0; no done pulse.
- Busy start: start held high for 12 cycles -> exactly one sequence, then a second sequence starting from the IDLE cycle after FIN.
- With MEM_WAIT_EN:
  - mem_rdy delayed 3 cycles -> T1 lasts 4 cycles and done is delayed by 3.
  - mem_rdy never asserted with WAIT_MAX=15 -> timeout and done pulse after 16 cycles in T1.

Source files
------------

// File: rtl/br_seq_pkg.sv
// Shared types and constants for the branch fetch sequencer.
package br_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_FIN
    } state_t;

    localparam logic [4:0] ALU_INC_C = 5'b11111;
    localparam logic [4:0] ALU_ADD_C = 5'b00011;
    localparam logic [4:0] OPC_BR_C  = 5'b10010;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of cycles spent waiting in T1; limit flags WAIT_MAX extra cycles.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clock,
    input  logic clear_n,
    input  logic clr,
    input  logic en,
    output logic limit
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] count;

    // Holding at the limit keeps the counter from ever wrapping.
    always_ff @(posedge clock) begin
        if (!clear_n || clr)
            count <= '0;
        else if (en && !limit)
            count <= count + CNT_W'(1);
    end

    assign limit = (count == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/br_fetch_seq.sv
// Fetch (T0-T2) plus conditional branch (T3-T6) control sequencer for the DataPath.
// Define MEM_WAIT_EN to let T1 stall on mem_rdy with a WAIT_MAX timeout.
module br_fetch_seq
    import br_seq_pkg::*;
#(
    parameter int               OPC_W    = 5,
    parameter int               ALU_W    = 5,
    parameter logic [ALU_W-1:0] ALU_INC  = ALU_W'(ALU_INC_C),
    parameter logic [ALU_W-1:0] ALU_ADD  = ALU_W'(ALU_ADD_C),
    parameter logic [OPC_W-1:0] OPC_BR   = OPC_W'(OPC_BR_C),
    parameter int               WAIT_MAX = 15
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             con_out,
    input  logic             mem_rdy,
    output logic             pc_out,
    output logic             mar_in,
    output logic             z_in,
    output logic             zlo_out,
    output logic             pc_in,
    output logic             mem_read,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             gra,
    output logic             r_out,
    output logic             con_in,
    output logic             y_in,
    output logic             c_out,
    output logic [ALU_W-1:0] alu_code,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             illegal,
    output logic             timeout
);

    state_t state, next_state;
    logic   taken_q, illegal_q;
    logic   is_illegal;
    logic   wait_expired;

    assign is_illegal = (state == S_DEC) && (ir_opcode != OPC_BR);

`ifdef MEM_WAIT_EN
    logic wait_limit;
    logic timeout_q;

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clock   (clock),
        .clear_n (clear_n),
        .clr     (state != S_T1),
        .en      (state == S_T1),
        .limit   (wait_limit)
    );

    // A late mem_rdy on the limit cycle still completes the fetch.
    assign wait_expired = (state == S_T1) && !mem_rdy && wait_limit;

    always_ff @(posedge clock) begin
        if (!clear_n)
            timeout_q <= 1'b0;
        else
            timeout_q <= wait_expired;
    end
`else
    logic [31:0] unused_cfg;
    assign unused_cfg   = {31'(WAIT_MAX), mem_rdy};
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!clear_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_T0;
            S_T0:   next_state = S_T1;
`ifdef MEM_WAIT_EN
            S_T1: begin
                if (mem_rdy)
                    next_state = S_T2;
                else if (wait_limit)
                    next_state = S_FIN;
            end
`else
            S_T1:   next_state = S_T2;
`endif
            S_T2:   next_state = S_DEC;
            S_DEC:  next_state = (ir_opcode == OPC_BR) ? S_T3 : S_FIN;
            S_T3:   next_state = S_T4;
            S_T4:   next_state = S_T5;
            S_T5:   next_state = S_T6;
            S_T6:   next_state = S_FIN;
            S_FIN:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Exit flags are registered on the transition into FIN, so they are live only there.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= is_illegal;
            if (state == S_T6)
                taken_q <= con_out;
            else if (is_illegal || wait_expired)
                taken_q <= 1'b0;
        end
    end

    always_comb begin
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        pc_in    = 1'b0;
        mem_read = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        gra      = 1'b0;
        r_out    = 1'b0;
        con_in   = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        alu_code = '0;
        busy     = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        timeout  = 1'b0;
        taken    = clear_n & taken_q;
        if (clear_n) begin
            busy = (state != S_IDLE);
            case (state)
                S_T0: begin
                    pc_out   = 1'b1;
                    mar_in   = 1'b1;
                    z_in     = 1'b1;
                    alu_code = ALU_INC;
                end
                S_T1: begin
                    zlo_out  = 1'b1;
                    pc_in    = 1'b1;
                    mem_read = 1'b1;
                    mdr_in   = 1'b1;
                end
                S_T2: begin
                    mdr_out = 1'b1;
                    ir_in   = 1'b1;
                end
                S_T3: begin
                    gra    = 1'b1;
                    r_out  = 1'b1;
                    con_in = 1'b1;
                end
                S_T4: begin
                    pc_out = 1'b1;
                    y_in   = 1'b1;
                end
                S_T5: begin
                    c_out    = 1'b1;
                    z_in     = 1'b1;
                    alu_code = ALU_ADD;
                end
                S_T6: begin
                    zlo_out = con_out;
                    pc_in   = con_out;
                end
                S_FIN: begin
                    done    = 1'b1;
                    illegal = illegal_q;
`ifdef MEM_WAIT_EN
                    timeout = timeout_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_br_fetch_seq.sv
// Cycle-by-cycle check of br_fetch_seq against a queue of expected per-cycle output vectors.
module tb_br_fetch_seq;

    localparam logic [4:0] ALU_INC = 5'b11111;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] OPC_BR  = 5'b10010;

    // strobe order: pc_out mar_in z_in zlo_out pc_in mem_read mdr_in mdr_out ir_in gra r_out con_in y_in c_out
    localparam logic [13:0] V_T0 = 14'b11100000000000;
    localparam logic [13:0] V_T1 = 14'b00011110000000;
    localparam logic [13:0] V_T2 = 14'b00000001100000;
    localparam logic [13:0] V_T3 = 14'b00000000011100;
    localparam logic [13:0] V_T4 = 14'b10000000000010;
    localparam logic [13:0] V_T5 = 14'b00100000000001;
    localparam logic [13:0] V_T6 = 14'b00011000000000;

    logic clock = 1'b0;
    logic clear_n, start, con_out, mem_rdy;
    logic [4:0] ir_opcode;
    logic pc_out, mar_in, z_in, zlo_out, pc_in, mem_read, mdr_in, mdr_out, ir_in;
    logic gra, r_out, con_in, y_in, c_out;
    logic [4:0] alu_code;
    logic busy, done, taken, illegal, timeout;

    br_fetch_seq dut (
        .clock(clock), .clear_n(clear_n), .start(start), .ir_opcode(ir_opcode),
        .con_out(con_out), .mem_rdy(mem_rdy),
        .pc_out(pc_out), .mar_in(mar_in), .z_in(z_in), .zlo_out(zlo_out), .pc_in(pc_in),
        .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .gra(gra), .r_out(r_out), .con_in(con_in), .y_in(y_in), .c_out(c_out),
        .alu_code(alu_code), .busy(busy), .done(done), .taken(taken),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] v;
        logic        rdy;
        logic [4:0]  opc;
        logic        con;
    } entry_t;

    entry_t     q[$];
    logic       model_taken = 1'b0;
    logic [4:0] seq_opc;
    logic       seq_con;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
`ifdef MEM_WAIT_EN
    localparam int WAIT_MAX = 15;
    int seq_delay = 0;
`endif

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [4:0] ro();
        return 5'($urandom);
    endfunction

    function automatic logic [23:0] mk(input logic [13:0] s, input logic [4:0] a,
                                       input logic b, input logic d, input logic t,
                                       input logic il, input logic to);
        return {s, a, b, d, t, il, to};
    endfunction

    task automatic push(input logic [23:0] v, input logic rdy, input logic [4:0] opc,
                        input logic con);
        entry_t e;
        e.v = v; e.rdy = rdy; e.opc = opc; e.con = con;
        q.push_back(e);
    endtask

    // Expected outputs of one whole sequence; taken shows the old value until FIN.
    task automatic push_seq();
        logic t0;
        t0 = model_taken;
        push(mk(V_T0, ALU_INC, 1, 0, t0, 0, 0), rb(), ro(), rb());
`ifdef MEM_WAIT_EN
        if (seq_delay > WAIT_MAX) begin
            for (int i = 0; i <= WAIT_MAX; i++)
                push(mk(V_T1, 0, 1, 0, t0, 0, 0), 1'b0, ro(), rb());
            push(mk(0, 0, 1, 1, 0, 0, 1), rb(), ro(), rb());
            model_taken = 1'b0;
            return;
        end
        for (int i = 0; i < seq_delay; i++)
            push(mk(V_T1, 0, 1, 0, t0, 0, 0), 1'b0, ro(), rb());
        push(mk(V_T1, 0, 1, 0, t0, 0, 0), 1'b1, ro(), rb());
`else
        push(mk(V_T1, 0, 1, 0, t0, 0, 0), rb(), ro(), rb());
`endif
        push(mk(V_T2, 0, 1, 0, t0, 0, 0), rb(), ro(), rb());
        push(mk(0, 0, 1, 0, t0, 0, 0), rb(), seq_opc, rb());
        if (seq_opc != OPC_BR) begin
            push(mk(0, 0, 1, 1, 0, 1, 0), rb(), ro(), rb());
            model_taken = 1'b0;
        end else begin
            push(mk(V_T3, 0, 1, 0, t0, 0, 0), rb(), ro(), rb());
            push(mk(V_T4, 0, 1, 0, t0, 0, 0), rb(), ro(), rb());
            push(mk(V_T5, ALU_ADD, 1, 0, t0, 0, 0), rb(), ro(), rb());
            push(mk(seq_con ? V_T6 : 14'd0, 0, 1, 0, t0, 0, 0), rb(), ro(), seq_con);
            push(mk(0, 0, 1, 1, seq_con, 0, 0), rb(), ro(), rb());
            model_taken = seq_con;
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs at the falling edge.
    task automatic cycle(input string name, input logic st, input logic rst);
        entry_t      e;
        logic [23:0] expv, obs;
        if (q.size() != 0) e = q[0];
        else begin
            e.v = mk(0, 0, 0, 0, model_taken, 0, 0);
            e.rdy = rb(); e.opc = ro(); e.con = rb();
        end
        clear_n = ~rst; start = st; mem_rdy = e.rdy; ir_opcode = e.opc; con_out = e.con;
        @(negedge clock);
        if (rst) begin
            expv = '0;
            q.delete();
            model_taken = 1'b0;
        end else begin
            expv = e.v;
            if (q.size() != 0) q.delete(0);
            else if (st) push_seq();
        end
        obs = {pc_out, mar_in, z_in, zlo_out, pc_in, mem_read, mdr_in, mdr_out, ir_in,
               gra, r_out, con_in, y_in, c_out, alu_code, busy, done, taken, illegal, timeout};
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, expv);
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            cycle(name, 1'b0, 1'b0);
            k++;
        end
        cycle(name, 1'b0, 1'b0);
    endtask

    task automatic run_one(input string name, input logic [4:0] opc, input logic con);
        seq_opc = opc;
        seq_con = con;
        cycle(name, 1'b1, 1'b0);
        drain(name);
    endtask

    task automatic test_reset();
        cycle("reset", rb(), 1'b1);
        cycle("reset", rb(), 1'b1);
        cycle("reset_release", 1'b0, 1'b0);
    endtask

    task automatic test_branch_not_taken();
        run_one("not_taken", OPC_BR, 1'b0);
    endtask

    task automatic test_branch_taken();
        run_one("taken", OPC_BR, 1'b1);
    endtask

    task automatic test_illegal();
        run_one("illegal", 5'b00011, 1'b1);
    endtask

    task automatic test_back_to_back();
        seq_opc = OPC_BR;
        seq_con = 1'b1;
        for (int i = 0; i < 12; i++) cycle("back_to_back", 1'b1, 1'b0);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        seq_opc = OPC_BR;
        seq_con = 1'b1;
        cycle("reset_mid", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle("reset_mid", rb(), 1'b0);
        cycle("reset_mid_t4", rb(), 1'b1);
        for (int i = 0; i < 3; i++) cycle("reset_mid_after", 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cycle("random_gap", 1'b0, 1'b0);
            run_one("random", ($urandom_range(0, 2) == 0) ? ro() : OPC_BR, rb());
        end
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        seq_delay = 3;
        run_one("mem_wait_3", OPC_BR, 1'b1);
        seq_delay = WAIT_MAX;
        run_one("mem_wait_limit", OPC_BR, 1'b1);
        seq_delay = 100;
        run_one("mem_timeout", OPC_BR, 1'b1);
        for (int n = 0; n < 6; n++) begin
            seq_delay = $urandom_range(0, WAIT_MAX + 2);
            run_one("mem_random", OPC_BR, rb());
        end
        seq_delay = 0;
    endtask
`endif

    initial begin
        clear_n = 1'b0; start = 1'b0; con_out = 1'b0; mem_rdy = 1'b0; ir_opcode = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_branch_not_taken();
        test_branch_taken();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
